// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ----------------------------------------------------------------------------
// Memory access sequencer that sits directly after the MMU. It takes one core
// access at a time (instruction fetch, data read or data write) and does one
// of two things:
//   - If the MMU reports a miss or a protection fault for the translated
//     address, it pulses mmu_fault and returns a faulted completion.
//   - Otherwise it runs one handshaked cycle on the physical memory bus and
//     returns the read data.
//
// Optional build macro: BUS_TIMEOUT_EN
//   When defined, a bus cycle that gets no bus_ack within TIMEOUT clocks is
//   abandoned. It completes to the core as a non-miss fault and sets the
//   sticky bus_timeout flag. When undefined, the bus waits indefinitely and
//   bus_timeout is tied low.
//
// Parameters
//   RV       data width in bits (byte lanes = RV/8)
//   PA       physical byte-address width (word address = PA - RV/16 bits)
//   TIMEOUT  bus watchdog limit in clocks, 1..255 (BUS_TIMEOUT_EN only)
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   req_valid/pc/write/be/wdata core request, held until req_ready
//   req_ready/fault/fault_miss  one-cycle completion pulse and its status
//   req_rdata                   read data of the last completed read
//   addrp                       translated word address from the MMU
//   mmu_miss_fault/prot_fault   combinational MMU fault indications
//   mmu_fault                   one-cycle pulse: MMU captures fault state
//   bus_req/write/addr/be/wdata registered bus cycle, held until bus_ack
//   bus_rdata, bus_ack          bus response
//   bus_timeout                 sticky watchdog flag
// ----------------------------------------------------------------------------
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for req_valid; decides fault vs bus access
// ST_FAULT | faulted completion cycle (req_ready + req_fault), then IDLE
// ST_BUS   | bus_req held until bus_ack (or watchdog expiry)
// ST_DONE  | normal completion cycle (req_ready, no fault), then IDLE

module mem_access_ctrl #(
    parameter int RV      = 16,
    parameter int PA      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req_valid,
    input  logic                 req_pc,
    input  logic                 req_write,
    input  logic [RV/8-1:0]      req_be,
    input  logic [RV-1:0]        req_wdata,
    output logic                 req_ready,
    output logic                 req_fault,
    output logic                 req_fault_miss,
    output logic [RV-1:0]        req_rdata,

    input  logic [PA-RV/16-1:0]  addrp,
    input  logic                 mmu_miss_fault,
    input  logic                 mmu_prot_fault,
    output logic                 mmu_fault,

    output logic                 bus_req,
    output logic                 bus_write,
    output logic [PA-RV/16-1:0]  bus_addr,
    output logic [RV/8-1:0]      bus_be,
    output logic [RV-1:0]        bus_wdata,
    input  logic [RV-1:0]        bus_rdata,
    input  logic                 bus_ack,
    output logic                 bus_timeout
);

    localparam int BW = RV / 8;
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FAULT = 2'd1,
        ST_BUS   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    logic   acc_write;

    // Fetches never write, whatever req_write says.
    assign acc_write = req_write & ~req_pc;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TMO_LIMIT;
    assign bus_timeout    = 1'b0;
`endif

    // All core-facing outputs are registered on the transition into the state
    // that presents them, so they are valid for exactly the one cycle spent in
    // ST_FAULT / ST_DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b0;
            req_fault      <= 1'b0;
            req_fault_miss <= 1'b0;
            req_rdata      <= '0;
            mmu_fault      <= 1'b0;
            bus_req        <= 1'b0;
            bus_write      <= 1'b0;
            bus_addr       <= '0;
            bus_be         <= '0;
            bus_wdata      <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt        <= 8'd0;
            bus_timeout    <= 1'b0;
`endif
        end else begin
            req_ready      <= 1'b0;
            req_fault      <= 1'b0;
            req_fault_miss <= 1'b0;
            mmu_fault      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (mmu_miss_fault || mmu_prot_fault) begin
                            // Miss wins when both are reported. The core keeps
                            // its request up during ST_FAULT, so the MMU still
                            // sees the faulting address when mmu_fault fires.
                            req_ready      <= 1'b1;
                            req_fault      <= 1'b1;
                            req_fault_miss <= mmu_miss_fault;
                            mmu_fault      <= 1'b1;
                            state          <= ST_FAULT;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_write <= acc_write;
                            bus_addr  <= addrp;
                            bus_be    <= acc_write ? req_be : {BW{1'b1}};
                            bus_wdata <= req_wdata;
`ifdef BUS_TIMEOUT_EN
                            tmo_cnt   <= 8'd0;
`endif
                            state     <= ST_BUS;
                        end
                    end
                end

                ST_FAULT: begin
                    state <= ST_IDLE;
                end

                ST_BUS: begin
                    // An ack in the same cycle as watchdog expiry still
                    // completes normally.
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        req_ready <= 1'b1;
                        if (!bus_write) begin
                            req_rdata <= bus_rdata;
                        end
                        state     <= ST_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LIMIT - 8'd1) begin
                        // Reuses ST_FAULT for the completion cycle; no
                        // mmu_fault because the translation itself was fine.
                        bus_req     <= 1'b0;
                        req_ready   <= 1'b1;
                        req_fault   <= 1'b1;
                        bus_timeout <= 1'b1;
                        state       <= ST_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed cases followed by randomized
// accesses. The driver pushes expected completions and expected bus cycles
// into queues; separate monitor and bus-responder processes pop and compare.
module tb_mem_access_ctrl;

`ifdef BUS_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 15;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_pc = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_be = 2'b00;
    logic [15:0] req_wdata = 16'h0;
    logic        req_ready;
    logic        req_fault;
    logic        req_fault_miss;
    logic [15:0] req_rdata;
    logic [14:0] addrp = 15'h0;
    logic        mmu_miss_fault = 1'b0;
    logic        mmu_prot_fault = 1'b0;
    logic        mmu_fault;
    logic        bus_req;
    logic        bus_write;
    logic [14:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = 16'h0;
    logic        bus_ack = 1'b0;
    logic        bus_timeout;

    mem_access_ctrl #(.RV(16), .PA(16), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pc(req_pc), .req_write(req_write),
        .req_be(req_be), .req_wdata(req_wdata), .req_ready(req_ready),
        .req_fault(req_fault), .req_fault_miss(req_fault_miss), .req_rdata(req_rdata),
        .addrp(addrp), .mmu_miss_fault(mmu_miss_fault), .mmu_prot_fault(mmu_prot_fault),
        .mmu_fault(mmu_fault),
        .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic        miss;
        logic        mmu;
        logic        tmo;
        logic [15:0] rdata;
        int          cycle;
    } resp_t;

    typedef struct {
        logic [14:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          d;      // ack delay in cycles after first bus_req; <0 = never
        logic [15:0] rdata;
    } bus_t;

    resp_t       exp_resp[$];
    bus_t        exp_bus[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic        after_ready = 1'b0;
    logic        exp_timeout = 1'b0;
    logic [15:0] last_rdata = 16'h0;
    logic        prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        resp_t r;
        if (mon_en) begin
            if (req_ready) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_ready: got req_ready=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    r = exp_resp.pop_front();
                    check("ready_cycle", cyc, r.cycle);
                    check("req_fault", {31'b0, req_fault}, {31'b0, r.fault});
                    check("mmu_fault", {31'b0, mmu_fault}, {31'b0, r.mmu});
                    if (r.fault)
                        check("req_fault_miss", {31'b0, req_fault_miss}, {31'b0, r.miss});
                    else
                        check("req_rdata", {16'b0, req_rdata}, {16'b0, r.rdata});
                    if (r.tmo) exp_timeout = 1'b1;
                end
            end else begin
                check("mmu_fault_idle", {31'b0, mmu_fault}, 32'd0);
            end
            check("bus_timeout", {31'b0, bus_timeout}, {31'b0, exp_timeout});
        end
    end

    // Bus responder: checks each new bus cycle and acks after the chosen delay.
    // Outside a bus cycle it throws in random stray acks, which must be ignored.
    always @(negedge clk) begin
        bus_t b;
        if (mon_en && bus_req && !prev_req) begin
            bus_ack = 1'b0;
            if (exp_bus.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_bus_req: got bus_req=1 expected no bus cycle (cycle %0d)", cyc);
            end else begin
                b = exp_bus.pop_front();
                check("bus_addr", {17'b0, bus_addr}, {17'b0, b.addr});
                check("bus_write", {31'b0, bus_write}, {31'b0, b.wr});
                check("bus_be", {30'b0, bus_be}, {30'b0, b.be});
                check("bus_wdata", {16'b0, bus_wdata}, {16'b0, b.wdata});
                if (b.d >= 0) begin
                    repeat (b.d) @(negedge clk);
                    bus_ack   = 1'b1;
                    bus_rdata = b.rdata;
                    @(negedge clk);
                    bus_ack   = 1'b0;
                    bus_rdata = 16'($urandom);
                end
            end
        end else if (!bus_req) begin
            bus_ack   = mon_en && ($urandom_range(0, 5) == 0);
            bus_rdata = 16'($urandom);
        end
        prev_req = bus_req;
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_resp.delete();
        exp_bus.delete();
        last_rdata  = 16'h0;
        exp_timeout = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        after_ready = 1'b0;
    endtask

    // Drives one request, queues its expectations, waits (bounded) for req_ready.
    task automatic do_txn(input logic pc, input logic wr, input logic [1:0] be,
                          input logic [15:0] wd, input logic [14:0] addr,
                          input logic miss, input logic prot, input int d,
                          input logic [15:0] rd, input int gap);
        int    n;
        logic  bw;
        logic  done;
        resp_t r;
        bus_t  b;
        if (gap == 0 && !after_ready) gap = 1;
        if (gap > 0) begin
            req_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        req_pc = pc; req_write = wr; req_be = be; req_wdata = wd; addrp = addr;
        mmu_miss_fault = miss; mmu_prot_fault = prot;
        req_valid = 1'b1;
        // Back-to-back: the DUT is in its completion cycle now, accepts next cycle.
        n  = (gap == 0) ? cyc + 1 : cyc;
        bw = wr & ~pc;
        r.fault = miss | prot;
        r.miss  = miss;
        r.mmu   = miss | prot;
        r.tmo   = 1'b0;
        if (r.fault) begin
            r.cycle = n + 1;
        end else begin
            b.addr = addr; b.wr = bw; b.be = bw ? be : 2'b11; b.wdata = wd;
            b.d = d; b.rdata = rd;
            exp_bus.push_back(b);
            if (d < 0) begin
                r.fault = 1'b1; r.miss = 1'b0; r.mmu = 1'b0; r.tmo = 1'b1;
                r.cycle = n + 1 + TB_TO;
            end else begin
                if (!bw) last_rdata = rd;
                r.cycle = n + 2 + d;
            end
        end
        r.rdata = last_rdata;
        exp_resp.push_back(r);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ready_wait: got no req_ready within 60 cycles expected completion (cycle %0d)", cyc);
            do_reset();
        end else begin
            after_ready = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {9'b0, req_ready, req_fault, req_fault_miss, mmu_fault, bus_req, bus_write,
               bus_be, bus_timeout, bus_addr},
              32'd0);
        check("rst_data", {req_rdata, bus_wdata}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // read 0x1234, ack 3 cycles after bus_req with 0xBEEF
        do_txn(1'b0, 1'b0, 2'b01, 16'h0000, 15'h1234, 1'b0, 1'b0, 3, 16'hBEEF, 1);
        // zero-wait write; req_rdata must stay 0xBEEF
        do_txn(1'b0, 1'b1, 2'b01, 16'hA55A, 15'h0042, 1'b0, 1'b0, 0, 16'h1111, 1);
        // fetch with miss
        do_txn(1'b1, 1'b0, 2'b10, 16'h0000, 15'h7FFF, 1'b1, 1'b0, 0, 16'h0, 0);
        // write with protection fault
        do_txn(1'b0, 1'b1, 2'b11, 16'h1357, 15'h0100, 1'b0, 1'b1, 0, 16'h0, 0);
        // both faults: miss wins
        do_txn(1'b0, 1'b0, 2'b11, 16'h0000, 15'h0200, 1'b1, 1'b1, 0, 16'h0, 2);
        // fetch with write bit set is still a read
        do_txn(1'b1, 1'b1, 2'b00, 16'hFFFF, 15'h0300, 1'b0, 1'b0, 1, 16'hC0DE, 0);
`ifdef BUS_TIMEOUT_EN
        do_txn(1'b0, 1'b0, 2'b11, 16'h0000, 15'h0400, 1'b0, 1'b0, -1, 16'h0, 1);
        do_txn(1'b0, 1'b0, 2'b11, 16'h0000, 15'h0401, 1'b0, 1'b0, 2, 16'h2468, 0);
`endif

        // reset two cycles into a bus cycle that is never acked
        begin
            bus_t b;
            req_valid = 1'b0;
            @(negedge clk);
            req_pc = 1'b0; req_write = 1'b0; req_be = 2'b11; addrp = 15'h0555;
            mmu_miss_fault = 1'b0; mmu_prot_fault = 1'b0;
            req_valid = 1'b1;
            b.addr = 15'h0555; b.wr = 1'b0; b.be = 2'b11; b.wdata = req_wdata;
            b.d = -1; b.rdata = 16'h0;
            exp_bus.push_back(b);
            @(negedge clk);
            do_reset();
            check("rst_mid_bus_req", {31'b0, bus_req}, 32'd0);
            check("rst_mid_rdata", {16'b0, req_rdata}, 32'd0);
        end

        for (int t = 0; t < 200; t++) begin
            do_txn(($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom), 16'($urandom),
                   15'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                   $urandom_range(0, 3), 16'($urandom), $urandom_range(0, 2));
        end

        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pending_resp", exp_resp.size(), 32'd0);
        check("pending_bus", exp_bus.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000 ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
